// File: rtl/core_mem_net_iface_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_mem_net_iface_pkg : flit format and FSM states shared by     |
// | the core network interface.  Rev 1.0                              |
// +------------------------------------------------------------------+
package core_mem_net_iface_pkg;

    localparam int PKG_ADDR_WIDTH = 32;
    localparam int PKG_FLIT_SIZE  = 64;
    localparam int PKG_WIDE_WIDTH = 256;
    localparam int FLITS_PER_WIDE = PKG_WIDE_WIDTH / PKG_FLIT_SIZE;
    localparam int SRC_W          = 4;
    localparam int PSIZE_W        = 8;

    typedef struct packed {
        logic [PKG_FLIT_SIZE-1:0]  data;
        logic [PKG_ADDR_WIDTH-1:0] addr;
        logic                      is_read;
        logic                      is_wide;
        logic [1:0]                transfer_type;
        logic [PSIZE_W-1:0]        payload_size;
        logic                      ipriority;
        logic [SRC_W-1:0]          src_core;
        logic                      last_flit;
    } generic_flit_t;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    typedef enum logic [0:0] {
        RX_COLLECT = 1'b0,
        RX_HOLD    = 1'b1
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/core_mem_net_iface_flit_reassembler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_mem_net_iface_flit_reassembler : collects response flits    |
// | into one wide word, drops foreign-source flits.  Rev 1.0          |
// +------------------------------------------------------------------+
module core_mem_net_iface_flit_reassembler
    import core_mem_net_iface_pkg::*;
#(
    parameter int CORE_ID    = 0,
    parameter int WIDE_WIDTH = 256,
    parameter int FLIT_SIZE  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  generic_flit_t         rx_flit,
    input  logic                  rx_req,
    output logic                  rx_ack,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDE_WIDTH-1:0] resp_data,
    output logic                  resp_is_wide,
    output logic                  drop_pulse,
    output logic                  resp_fire
);

    localparam int FPW   = WIDE_WIDTH / FLIT_SIZE;
    localparam int IDX_W = (FPW > 1) ? $clog2(FPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FPW - 1);
    localparam logic [SRC_W-1:0] C_CORE   = SRC_W'(CORE_ID);

    rx_state_t             state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [WIDE_WIDTH-1:0] buf_q;
    logic                  wide_q;
    logic                  drop_q;

    logic w_take;
    logic w_own;
    logic w_unused;

    assign rx_ack       = !rst && (state_q == RX_COLLECT);
    assign w_take       = rx_req && rx_ack;
    assign w_own        = (rx_flit.src_core == C_CORE);
    assign resp_valid   = (state_q == RX_HOLD);
    assign resp_data    = buf_q;
    assign resp_is_wide = wide_q;
    assign drop_pulse   = drop_q;
    assign resp_fire    = resp_valid && resp_ready && !rst;
    assign w_unused     = ^{rx_flit.addr, rx_flit.is_read, rx_flit.transfer_type,
                            rx_flit.payload_size, rx_flit.ipriority};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_COLLECT;
            idx_q   <= '0;
            buf_q   <= '0;
            wide_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                RX_COLLECT: begin
                    if (w_take) begin
                        if (!w_own) begin
                            drop_q <= 1'b1;
                        end else begin
                            buf_q[int'(idx_q)*FLIT_SIZE +: FLIT_SIZE] <= FLIT_SIZE'(rx_flit.data);
                            idx_q  <= idx_q + 1'b1;
                            wide_q <= rx_flit.is_wide;
                            // A full buffer also closes the word even without last_flit.
                            if (rx_flit.last_flit || (idx_q == LAST_IDX)) begin
                                state_q <= RX_HOLD;
                            end
                        end
                    end
                end
                RX_HOLD: begin
                    if (resp_ready) begin
                        buf_q   <= '0;
                        idx_q   <= '0;
                        wide_q  <= 1'b0;
                        state_q <= RX_COLLECT;
                    end
                end
                default: state_q <= RX_COLLECT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_mem_net_iface.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_mem_net_iface : packetizes core memory requests into flits   |
// | and returns reassembled responses; caps reads in flight. Rev 1.0  |
// +------------------------------------------------------------------+
module core_mem_net_iface
    import core_mem_net_iface_pkg::*;
#(
    parameter int CORE_ID    = 0,
    parameter int ADDR_WIDTH = 32,
    parameter int WIDE_WIDTH = 256,
    parameter int FLIT_SIZE  = 64,
    parameter int MAX_OUT    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         srf_enable,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic                         req_is_read,
    input  logic                         req_is_wide,
    input  logic [WIDE_WIDTH-1:0]        req_data,
    output generic_flit_t                tx_flit,
    output logic                         tx_req,
    input  logic                         tx_ack,
    input  generic_flit_t                rx_flit,
    input  logic                         rx_req,
    output logic                         rx_ack,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [WIDE_WIDTH-1:0]        resp_data,
    output logic                         resp_is_wide,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         drop_pulse
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int FPW   = WIDE_WIDTH / FLIT_SIZE;
    localparam int IDX_W = (FPW > 1) ? $clog2(FPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FPW - 1);
    localparam logic [OUT_W-1:0] C_MAX_OUT = OUT_W'(MAX_OUT);

    tx_state_t             tx_state_q;
    logic [IDX_W-1:0]      k_q;
    logic [IDX_W-1:0]      last_k_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  read_q;
    logic                  wide_q;
    logic [WIDE_WIDTH-1:0] data_q;
    logic [OUT_W-1:0]      outstanding_q;
    logic [OUT_W-1:0]      outstanding_d;

    logic w_accept;
    logic w_wide;
    logic w_resp_fire;

    assign req_ready   = !rst && (tx_state_q == TX_IDLE) && (outstanding_q < C_MAX_OUT);
    assign w_accept    = req_valid && req_ready;
    assign w_wide      = req_is_wide && srf_enable;
    assign tx_req      = (tx_state_q == TX_SEND);
    assign outstanding = outstanding_q;

    always_comb begin
        outstanding_d = outstanding_q;
        if (w_accept && req_is_read && !w_resp_fire) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!(w_accept && req_is_read) && w_resp_fire && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_comb begin
        tx_flit = '0;
        if (tx_state_q == TX_SEND) begin
            tx_flit.data          = PKG_FLIT_SIZE'(data_q[int'(k_q)*FLIT_SIZE +: FLIT_SIZE]);
            tx_flit.addr          = PKG_ADDR_WIDTH'(addr_q);
            tx_flit.is_read       = read_q;
            tx_flit.is_wide       = wide_q;
            tx_flit.transfer_type = wide_q ? 2'd1 : 2'd0;
            tx_flit.payload_size  = wide_q ? PSIZE_W'(WIDE_WIDTH/8) : PSIZE_W'(FLIT_SIZE/8);
            tx_flit.ipriority     = wide_q;
            tx_flit.src_core      = SRC_W'(CORE_ID);
            tx_flit.last_flit     = (k_q == last_k_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q    <= TX_IDLE;
            k_q           <= '0;
            last_k_q      <= '0;
            addr_q        <= '0;
            read_q        <= 1'b0;
            wide_q        <= 1'b0;
            data_q        <= '0;
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            case (tx_state_q)
                TX_IDLE: begin
                    if (w_accept) begin
                        addr_q     <= req_addr;
                        read_q     <= req_is_read;
                        wide_q     <= w_wide;
                        data_q     <= req_data;
                        k_q        <= '0;
                        // Only wide stores carry a full line; reads and narrow stores are one flit.
                        last_k_q   <= (w_wide && !req_is_read) ? LAST_IDX : '0;
                        tx_state_q <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_ack) begin
                        if (k_q == last_k_q) begin
                            tx_state_q <= TX_IDLE;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    core_mem_net_iface_flit_reassembler #(
        .CORE_ID    (CORE_ID),
        .WIDE_WIDTH (WIDE_WIDTH),
        .FLIT_SIZE  (FLIT_SIZE)
    ) u_reasm (
        .clk          (clk),
        .rst          (rst),
        .rx_flit      (rx_flit),
        .rx_req       (rx_req),
        .rx_ack       (rx_ack),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_is_wide (resp_is_wide),
        .drop_pulse   (drop_pulse),
        .resp_fire    (w_resp_fire)
    );

endmodule
`default_nettype wire

// File: tb/tb_core_mem_net_iface.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_core_mem_net_iface : directed self-checking bench for          |
// | core_mem_net_iface (CORE_ID=0, MAX_OUT=2).  Rev 1.0               |
// +------------------------------------------------------------------+
module tb_core_mem_net_iface;
    import core_mem_net_iface_pkg::*;

    localparam int MAX_OUT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          srf_enable;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          req_is_read;
    logic          req_is_wide;
    logic [255:0]  req_data;
    generic_flit_t tx_flit;
    logic          tx_req;
    logic          tx_ack;
    generic_flit_t rx_flit;
    logic          rx_req;
    logic          rx_ack;
    logic          resp_valid;
    logic          resp_ready;
    logic [255:0]  resp_data;
    logic          resp_is_wide;
    logic [1:0]    outstanding;
    logic          drop_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] wd;

    always #5 clk = ~clk;

    core_mem_net_iface #(
        .CORE_ID    (0),
        .ADDR_WIDTH (32),
        .WIDE_WIDTH (256),
        .FLIT_SIZE  (64),
        .MAX_OUT    (MAX_OUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .srf_enable   (srf_enable),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_is_read  (req_is_read),
        .req_is_wide  (req_is_wide),
        .req_data     (req_data),
        .tx_flit      (tx_flit),
        .tx_req       (tx_req),
        .tx_ack       (tx_ack),
        .rx_flit      (rx_flit),
        .rx_req       (rx_req),
        .rx_ack       (rx_ack),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_is_wide (resp_is_wide),
        .outstanding  (outstanding),
        .drop_pulse   (drop_pulse)
    );

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
        n_tests++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL rst_tx_req got %b exp 0", tx_req); end
        n_tests++; if (rx_ack !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ack got %b exp 0", rx_ack); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
        n_tests++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL rst_outstanding got %0d exp 0", outstanding); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_ready got %b exp 1", req_ready); end
        n_tests++; if (rx_ack !== 1'b1) begin n_fail++; $display("FAIL post_rst_rx_ack got %b exp 1", rx_ack); end
    endtask

    task automatic test_narrow_write;
        req_valid   = 1'b1;
        req_addr    = 32'h0000_1000;
        req_is_read = 1'b0;
        req_is_wide = 1'b0;
        req_data    = '0;
        req_data[63:0] = 64'hDEADBEEF_CAFEF00D;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL nw_req_ready got %b exp 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        n_tests++; if (tx_req !== 1'b1) begin n_fail++; $display("FAIL nw_tx_req got %b exp 1", tx_req); end
        n_tests++; if (tx_flit.data !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL nw_data got %h exp deadbeefcafef00d", tx_flit.data); end
        n_tests++; if (tx_flit.addr !== 32'h1000) begin n_fail++; $display("FAIL nw_addr got %h exp 00001000", tx_flit.addr); end
        n_tests++; if (tx_flit.last_flit !== 1'b1) begin n_fail++; $display("FAIL nw_last got %b exp 1", tx_flit.last_flit); end
        n_tests++; if (tx_flit.payload_size !== 8'd8) begin n_fail++; $display("FAIL nw_psize got %0d exp 8", tx_flit.payload_size); end
        n_tests++; if (tx_flit.is_read !== 1'b0) begin n_fail++; $display("FAIL nw_is_read got %b exp 0", tx_flit.is_read); end
        n_tests++; if (tx_flit.is_wide !== 1'b0) begin n_fail++; $display("FAIL nw_is_wide got %b exp 0", tx_flit.is_wide); end
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        n_tests++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL nw_tx_req_after got %b exp 0", tx_req); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL nw_req_ready_after got %b exp 1", req_ready); end
        n_tests++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL nw_outstanding got %0d exp 0", outstanding); end
    endtask

    task automatic test_wide_write;
        wd = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        srf_enable  = 1'b1;
        req_valid   = 1'b1;
        req_addr    = 32'h0000_2000;
        req_is_read = 1'b0;
        req_is_wide = 1'b1;
        req_data    = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        srf_enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (tx_req !== 1'b1) begin n_fail++; $display("FAIL ww_tx_req[%0d] got %b exp 1", k, tx_req); end
            n_tests++; if (tx_flit.data !== wd[k*64 +: 64]) begin n_fail++; $display("FAIL ww_data[%0d] got %h exp %h", k, tx_flit.data, wd[k*64 +: 64]); end
            n_tests++; if (tx_flit.last_flit !== (k == 3)) begin n_fail++; $display("FAIL ww_last[%0d] got %b exp %b", k, tx_flit.last_flit, (k == 3)); end
            n_tests++; if (tx_flit.payload_size !== 8'd32) begin n_fail++; $display("FAIL ww_psize[%0d] got %0d exp 32", k, tx_flit.payload_size); end
            n_tests++; if (tx_flit.transfer_type !== 2'd1) begin n_fail++; $display("FAIL ww_ttype[%0d] got %0d exp 1", k, tx_flit.transfer_type); end
            if (k == 1) begin
                tx_ack = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    n_tests++; if (tx_flit.data !== wd[127:64]) begin n_fail++; $display("FAIL ww_stall_data got %h exp %h", tx_flit.data, wd[127:64]); end
                    n_tests++; if (tx_req !== 1'b1) begin n_fail++; $display("FAIL ww_stall_tx_req got %b exp 1", tx_req); end
                end
            end
            tx_ack = 1'b1;
            @(negedge clk);
        end
        tx_ack = 1'b0;
        n_tests++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL ww_tx_req_end got %b exp 0", tx_req); end
        n_tests++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL ww_outstanding got %0d exp 0", outstanding); end
    endtask

    task automatic test_outstanding_cap;
        logic [255:0] exp_d;
        tx_ack      = 1'b1;
        req_valid   = 1'b1;
        req_addr    = 32'h0000_3000;
        req_is_read = 1'b1;
        req_is_wide = 1'b0;
        req_data    = '0;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL oc_ready0 got %b exp 1", req_ready); end
        @(negedge clk);
        n_tests++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL oc_out1 got %0d exp 1", outstanding); end
        repeat (3) @(negedge clk);
        n_tests++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL oc_out2 got %0d exp 2", outstanding); end
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL oc_ready_cap got %b exp 0", req_ready); end
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL oc_ready_cap2 got %b exp 0", req_ready); end
        n_tests++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL oc_out2_hold got %0d exp 2", outstanding); end
        rx_flit = '0;
        rx_flit.data      = 64'h0000_0000_0000_ABCD;
        rx_flit.is_read   = 1'b1;
        rx_flit.last_flit = 1'b1;
        rx_req = 1'b1;
        @(negedge clk);
        rx_req = 1'b0;
        exp_d = '0;
        exp_d[63:0] = 64'h0000_0000_0000_ABCD;
        n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL oc_resp_valid got %b exp 1", resp_valid); end
        n_tests++; if (resp_data !== exp_d) begin n_fail++; $display("FAIL oc_resp_data got %h exp %h", resp_data, exp_d); end
        n_tests++; if (resp_is_wide !== 1'b0) begin n_fail++; $display("FAIL oc_resp_wide got %b exp 0", resp_is_wide); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_tests++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL oc_out_after_resp got %0d exp 1", outstanding); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL oc_ready_reopen got %b exp 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        n_tests++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL oc_out_third got %0d exp 2", outstanding); end
        n_tests++; if (tx_req !== 1'b1) begin n_fail++; $display("FAIL oc_third_tx_req got %b exp 1", tx_req); end
        @(negedge clk);
        tx_ack = 1'b0;
        n_tests++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL oc_tx_idle got %b exp 0", tx_req); end
    endtask

    task automatic test_wide_response;
        logic [255:0] wexp;
        logic [255:0] nexp;
        wexp = {64'hA4A4_0000_0000_0004, 64'hA3A3_0000_0000_0003,
                64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001};
        for (int k = 0; k < 4; k++) begin
            rx_flit = '0;
            rx_flit.data      = wexp[k*64 +: 64];
            rx_flit.is_read   = 1'b1;
            rx_flit.is_wide   = 1'b1;
            rx_flit.last_flit = (k == 3);
            rx_req = 1'b1;
            n_tests++; if (rx_ack !== 1'b1) begin n_fail++; $display("FAIL wr_rx_ack[%0d] got %b exp 1", k, rx_ack); end
            @(negedge clk);
        end
        rx_flit = '0;
        rx_flit.data      = 64'h55;
        rx_flit.last_flit = 1'b1;
        rx_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_hold_valid[%0d] got %b exp 1", c, resp_valid); end
            n_tests++; if (rx_ack !== 1'b0) begin n_fail++; $display("FAIL wr_hold_rx_ack[%0d] got %b exp 0", c, rx_ack); end
            n_tests++; if (resp_data !== wexp) begin n_fail++; $display("FAIL wr_data[%0d] got %h exp %h", c, resp_data, wexp); end
            n_tests++; if (resp_is_wide !== 1'b1) begin n_fail++; $display("FAIL wr_is_wide[%0d] got %b exp 1", c, resp_is_wide); end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_valid_drop got %b exp 0", resp_valid); end
        n_tests++; if (rx_ack !== 1'b1) begin n_fail++; $display("FAIL wr_rx_ack_reopen got %b exp 1", rx_ack); end
        n_tests++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL wr_outstanding got %0d exp 1", outstanding); end
        @(negedge clk);
        rx_req = 1'b0;
        nexp = '0;
        nexp[63:0] = 64'h55;
        n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL wr5_valid got %b exp 1", resp_valid); end
        n_tests++; if (resp_data !== nexp) begin n_fail++; $display("FAIL wr5_data got %h exp %h", resp_data, nexp); end
        n_tests++; if (resp_is_wide !== 1'b0) begin n_fail++; $display("FAIL wr5_is_wide got %b exp 0", resp_is_wide); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_tests++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL wr5_outstanding got %0d exp 0", outstanding); end
    endtask

    task automatic test_drop;
        rx_flit = '0;
        rx_flit.data      = 64'h77;
        rx_flit.src_core  = 4'd1;
        rx_flit.last_flit = 1'b1;
        rx_req = 1'b1;
        n_tests++; if (rx_ack !== 1'b1) begin n_fail++; $display("FAIL drop_rx_ack got %b exp 1", rx_ack); end
        @(negedge clk);
        rx_req = 1'b0;
        n_tests++; if (drop_pulse !== 1'b1) begin n_fail++; $display("FAIL drop_pulse got %b exp 1", drop_pulse); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL drop_resp_valid got %b exp 0", resp_valid); end
        @(negedge clk);
        n_tests++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL drop_pulse_end got %b exp 0", drop_pulse); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL drop_resp_valid2 got %b exp 0", resp_valid); end
        n_tests++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL drop_outstanding got %0d exp 0", outstanding); end
    endtask

    task automatic test_reset_midflight;
        tx_ack      = 1'b1;
        req_valid   = 1'b1;
        req_addr    = 32'h0000_4000;
        req_is_read = 1'b1;
        req_is_wide = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        tx_ack = 1'b0;
        n_tests++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL rm_pre_outstanding got %0d exp 1", outstanding); end
        srf_enable  = 1'b1;
        req_valid   = 1'b1;
        req_is_read = 1'b0;
        req_is_wide = 1'b1;
        req_data    = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        srf_enable = 1'b0;
        tx_ack     = 1'b1;
        repeat (2) @(negedge clk);
        tx_ack = 1'b0;
        n_tests++; if (tx_flit.data !== wd[191:128]) begin n_fail++; $display("FAIL rm_flit2_data got %h exp %h", tx_flit.data, wd[191:128]); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL rm_tx_req got %b exp 0", tx_req); end
        n_tests++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL rm_outstanding got %0d exp 0", outstanding); end
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rm_req_ready_in_rst got %b exp 0", req_ready); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_req_ready_after got %b exp 1", req_ready); end
        n_tests++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL rm_tx_req_after got %b exp 0", tx_req); end
    endtask

    initial begin
        rst         = 1'b1;
        srf_enable  = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_is_read = 1'b0;
        req_is_wide = 1'b0;
        req_data    = '0;
        tx_ack      = 1'b0;
        rx_flit     = '0;
        rx_req      = 1'b0;
        resp_ready  = 1'b0;
        wd          = '0;
        @(negedge clk);
        test_reset();
        test_narrow_write();
        test_wide_write();
        test_outstanding_cap();
        test_wide_response();
        test_drop();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
